// File: rtl/ahb_interconnect.sv
// -----------------------------------------------------------------------------
// ahb_interconnect
// One AHB-Lite master to NUM_SLAVES slaves: address decoder, data-phase
// response multiplexer and a built-in default slave for unmapped space.
//
// Slave i owns [i << SLAVE_ADDR_BITS, ((i+1) << SLAVE_ADDR_BITS) - 1].
// Unmapped NONSEQ/SEQ transfers get the two-cycle ERROR response from the
// default slave; unmapped IDLE/BUSY complete with zero waits and OKAY.
//
// Ports:
//   HCLK         clock, rising edge
//   HRESETn      synchronous reset, ACTIVE HIGH despite the name
//   HADDR        master address
//   HTRANS       master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   HWRITE       master direction (error logging only)
//   HRDATA       read data to master
//   HREADY       ready to master, also broadcast to slaves
//   HRESP        response to master (0 OKAY, 1 ERROR)
//   HSEL_S       one-hot slave selects
//   HRDATA_S     slave read data, slave i at [i*W +: W]
//   HREADYOUT_S  slave ready outputs
//   HRESP_S      slave responses
//
// Optional feature (macro AHB_IC_ERR_LOG_EN) adds:
//   ERR_ADDR     HADDR of the most recent transfer that entered DS_ERR1
//   ERR_WRITE    HWRITE of that transfer
//   ERR_CNT      saturating count of such transfers
// -----------------------------------------------------------------------------
module ahb_interconnect #(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int NUM_SLAVES        = 4,
  parameter int SLAVE_ADDR_BITS   = 28
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  input  logic [AHB_ADDRESS_WIDTH-1:0]         HADDR,
  input  logic [1:0]                           HTRANS,
  input  logic                                 HWRITE,
  output logic [AHB_DATA_WIDTH-1:0]            HRDATA,
  output logic                                 HREADY,
  output logic                                 HRESP,
  output logic [NUM_SLAVES-1:0]                HSEL_S,
  input  logic [NUM_SLAVES*AHB_DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]                HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]                HRESP_S
`ifdef AHB_IC_ERR_LOG_EN
  ,
  output logic [AHB_ADDRESS_WIDTH-1:0]         ERR_ADDR,
  output logic                                 ERR_WRITE,
  output logic [15:0]                          ERR_CNT
`endif
);

  localparam int RW   = AHB_ADDRESS_WIDTH - SLAVE_ADDR_BITS;
  localparam int SELW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // HRESETn is an active-high reset; alias it so the logic reads naturally.
  logic rst_s;
  assign rst_s = HRESETn;

  logic [RW-1:0]             region_s;
  logic                      dec_hit_s;
  logic [SELW-1:0]           dec_idx_s;
  logic [NUM_SLAVES-1:0]     hsel_s;
  logic [AHB_DATA_WIDTH-1:0] hrdata_s;
  logic                      hready_s;
  logic                      hresp_s;
  logic                      ds_go_err_s;

  logic [SELW-1:0] dp_sel_d, dp_sel_q;
  logic            dp_default_d, dp_default_q;
  ds_state_e       ds_state_d, ds_state_q;
  logic            ds_hreadyout_d, ds_hreadyout_q;
  logic            ds_hresp_d, ds_hresp_q;

  assign region_s = HADDR[AHB_ADDRESS_WIDTH-1:SLAVE_ADDR_BITS];

  // Address decode: find which slave region (if any) HADDR falls into.
  always_comb begin
    dec_hit_s = 1'b0;
    dec_idx_s = {SELW{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (region_s == RW'(i)) begin
        dec_hit_s = 1'b1;
        dec_idx_s = SELW'(i);
      end else begin
        dec_idx_s = dec_idx_s;
      end
    end
  end

  // Slave selects: one-hot decode, all zero while reset is held.
  always_comb begin
    hsel_s = {NUM_SLAVES{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hsel_s[i] = ~rst_s & (region_s == RW'(i));
    end
  end

  assign HSEL_S = hsel_s;

  // Response mux driven by the registered data-phase owner.
  always_comb begin
    hrdata_s = {AHB_DATA_WIDTH{1'b0}};
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    if (rst_s) begin
      hready_s = 1'b1;
    end else if (dp_default_q) begin
      hready_s = ds_hreadyout_q;
      hresp_s  = ds_hresp_q;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dp_sel_q == SELW'(i)) begin
          hrdata_s = HRDATA_S[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
          hready_s = HREADYOUT_S[i];
          hresp_s  = HRESP_S[i];
        end else begin
          hrdata_s = hrdata_s;
        end
      end
    end
  end

  assign HRDATA = hrdata_s;
  assign HREADY = hready_s;
  assign HRESP  = hresp_s;

  // Data-phase owner: captured only when the current data phase completes.
  always_comb begin
    if (hready_s) begin
      dp_sel_d     = dec_idx_s;
      dp_default_d = ~dec_hit_s;
    end else begin
      dp_sel_d     = dp_sel_q;
      dp_default_d = dp_default_q;
    end
  end

  // Data-phase owner registers.
  always_ff @(posedge HCLK) begin
    if (rst_s) begin
      dp_sel_q     <= {SELW{1'b0}};
      dp_default_q <= 1'b1;
    end else begin
      dp_sel_q     <= dp_sel_d;
      dp_default_q <= dp_default_d;
    end
  end

  // An active transfer to unmapped space being accepted starts an ERROR.
  assign ds_go_err_s = hready_s & ~dec_hit_s & HTRANS[1];

  // Default slave next state and its registered outputs.
  always_comb begin
    case (ds_state_q)
      DS_IDLE: ds_state_d = ds_go_err_s ? DS_ERR1 : DS_IDLE;
      DS_ERR1: ds_state_d = DS_ERR2;
      DS_ERR2: ds_state_d = ds_go_err_s ? DS_ERR1 : DS_IDLE;
      default: ds_state_d = DS_IDLE;
    endcase
    ds_hreadyout_d = (ds_state_d != DS_ERR1);
    ds_hresp_d     = (ds_state_d != DS_IDLE);
  end

  // Default slave state register.
  always_ff @(posedge HCLK) begin
    if (rst_s) begin
      ds_state_q     <= DS_IDLE;
      ds_hreadyout_q <= 1'b1;
      ds_hresp_q     <= 1'b0;
    end else begin
      ds_state_q     <= ds_state_d;
      ds_hreadyout_q <= ds_hreadyout_d;
      ds_hresp_q     <= ds_hresp_d;
    end
  end

`ifdef AHB_IC_ERR_LOG_EN
  logic [AHB_ADDRESS_WIDTH-1:0] err_addr_d, err_addr_q;
  logic                         err_write_d, err_write_q;
  logic [15:0]                  err_cnt_d, err_cnt_q;
  logic                         err_log_s;

  // Every entry into DS_ERR1 is a new erroring transfer.
  assign err_log_s = (ds_state_d == DS_ERR1);

  // Error log next values; the counter saturates at all ones.
  always_comb begin
    if (err_log_s) begin
      err_addr_d  = HADDR;
      err_write_d = HWRITE;
      err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
    end else begin
      err_addr_d  = err_addr_q;
      err_write_d = err_write_q;
      err_cnt_d   = err_cnt_q;
    end
  end

  // Error log registers.
  always_ff @(posedge HCLK) begin
    if (rst_s) begin
      err_addr_q  <= {AHB_ADDRESS_WIDTH{1'b0}};
      err_write_q <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ERR_ADDR  = err_addr_q;
  assign ERR_WRITE = err_write_q;
  assign ERR_CNT   = err_cnt_q;
`endif

  // Inputs that only matter to the slaves or to the optional log.
  logic unused_pins_s;
  assign unused_pins_s = ^{HADDR[SLAVE_ADDR_BITS-1:0], HTRANS[0], HWRITE};

endmodule
